trap_ctrl_gen: RTL and testbench



---
 rtl/trap_ctrl_gen.sv | 251 +++++++++++++++++++++++++
 tb/tb_trap_ctrl_gen.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl_gen.sv
// Pipeline trap controller: stall vectors, exception/interrupt arbitration, CSR strobes, fetch redirect.
// Optional sleep support (wfi_i port, SLEEP state) is built when CTRL_WFI_EN is defined.
module trap_ctrl_gen #(
   parameter int unsigned NUM_STAGES = 6,
   parameter int unsigned NUM_LIC    = 4,
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic                  clk_i,
   input  logic                  n_rst_i,
   input  logic [NUM_STAGES-1:0] stallreq_i,
   input  logic [6:0]            exception_i,
   input  logic [31:0]           pc_i,
   input  logic [31:0]           inst_i,
   input  logic                  mstatus_mie_i,
   input  logic [31:0]           mie_i,
   input  logic [31:0]           mip_i,
   input  logic [31:0]           mtvec_i,
   input  logic [31:0]           mepc_i,
`ifdef CTRL_WFI_EN
   input  logic                  wfi_i,
`endif
   output logic [NUM_STAGES-1:0] stall_o,
   output logic                  flush_o,
   output logic [31:0]           new_pc_o,
   output logic                  set_cause_o,
   output logic [31:0]           mcause_o,
   output logic                  set_epc_o,
   output logic [31:0]           epc_o,
   output logic                  set_mtval_o,
   output logic [31:0]           mtval_o,
   output logic                  mie_clear_o,
   output logic                  mie_set_o
);

   localparam int EX_MRET      = 0;
   localparam int EX_ECALL     = 1;
   localparam int EX_EBREAK    = 2;
   localparam int EX_MIS_INST  = 3;
   localparam int EX_ILLEGAL   = 4;
   localparam int EX_MIS_STORE = 5;
   localparam int EX_MIS_LOAD  = 6;

   localparam int          MEM_STAGE = int'(NUM_STAGES) - 2;
   localparam logic [31:0] LIC_MASK  = ((32'd1 << NUM_LIC) - 32'd1) << 16;
   localparam logic [31:0] IP_MASK   = LIC_MASK | 32'h0000_0888;

   typedef enum logic [2:0] {
      ST_RESET       = 3'd0,
      ST_OPERATING   = 3'd1,
      ST_DRAIN       = 3'd2,
      ST_TRAP_TAKEN  = 3'd3,
      ST_TRAP_RETURN = 3'd4
`ifdef CTRL_WFI_EN
      ,
      ST_SLEEP       = 3'd5
`endif
   } state_e;

   state_e      state_q, state_d;
   logic [4:0]  cause_q, cause_d;
   logic        irq_q, irq_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] mtval_q, mtval_d;
   logic        set_mtval_q, set_mtval_d;

   logic [31:0] ip;
   logic        irq_take;
   logic [4:0]  irq_cause;
   logic        exc_take;
   logic [4:0]  exc_cause;
   logic [31:0] exc_tval;
   logic        trap;
   logic        mret;
   logic        mem_stall;
   logic        latch_trap;
   logic        stall_acc;
   logic [31:0] trap_base;
   logic        unused_wb_stallreq;

   assign ip                 = mie_i & mip_i & IP_MASK;
   assign irq_take           = mstatus_mie_i & (|ip);
   assign exc_take           = |exception_i[EX_MIS_LOAD:EX_ECALL];
   assign trap               = irq_take | exc_take;
   assign mret               = exception_i[EX_MRET];
   assign mem_stall          = stallreq_i[MEM_STAGE];
   assign unused_wb_stallreq = stallreq_i[NUM_STAGES-1];

   // NOTE: later assignments override earlier ones, so sources are listed lowest priority first.
   always_comb begin
      irq_cause = 5'd0;
      if (ip[7])  irq_cause = 5'd7;
      if (ip[3])  irq_cause = 5'd3;
      if (ip[11]) irq_cause = 5'd11;
      for (int i = 0; i < int'(NUM_LIC); i++) begin
         if (ip[16+i]) irq_cause = 5'(16 + i);
      end
   end

   always_comb begin
      exc_cause = 5'd0;
      exc_tval  = 32'd0;
      if (exception_i[EX_MIS_INST]) begin
         exc_cause = 5'd0;
         exc_tval  = pc_i;
      end else if (exception_i[EX_ILLEGAL]) begin
         exc_cause = 5'd2;
         exc_tval  = inst_i;
      end else if (exception_i[EX_EBREAK]) begin
         exc_cause = 5'd3;
         exc_tval  = pc_i;
      end else if (exception_i[EX_MIS_STORE]) begin
         exc_cause = 5'd6;
         exc_tval  = pc_i;
      end else if (exception_i[EX_MIS_LOAD]) begin
         exc_cause = 5'd4;
         exc_tval  = pc_i;
      end else if (exception_i[EX_ECALL]) begin
         exc_cause = 5'd11;
      end
   end

   // NOTE: every variable gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d    = state_q;
      latch_trap = 1'b0;
      case (state_q)
         ST_RESET: state_d = ST_OPERATING;
         ST_OPERATING: begin
            if (trap) begin
               latch_trap = 1'b1;
               state_d    = mem_stall ? ST_DRAIN : ST_TRAP_TAKEN;
            end else if (mret) begin
               state_d = ST_TRAP_RETURN;
`ifdef CTRL_WFI_EN
            end else if (wfi_i) begin
               state_d = ST_SLEEP;
`endif
            end
         end
         ST_DRAIN: begin
            if (!mem_stall) state_d = ST_TRAP_TAKEN;
         end
         ST_TRAP_TAKEN:  state_d = ST_OPERATING;
         ST_TRAP_RETURN: state_d = ST_OPERATING;
`ifdef CTRL_WFI_EN
         ST_SLEEP: begin
            // Wake ignores the global enable; only an enabled wake becomes a trap.
            if (|ip) begin
               if (mstatus_mie_i) begin
                  latch_trap = 1'b1;
                  state_d    = ST_TRAP_TAKEN;
               end else begin
                  state_d = ST_OPERATING;
               end
            end
         end
`endif
         default: state_d = ST_OPERATING;
      endcase
   end

   // Trap context is captured once at trap entry and held through DRAIN.
   always_comb begin
      cause_d     = cause_q;
      irq_d       = irq_q;
      epc_d       = epc_q;
      mtval_d     = mtval_q;
      set_mtval_d = set_mtval_q;
      if (latch_trap) begin
         irq_d       = irq_take;
         cause_d     = irq_take ? irq_cause : exc_cause;
         epc_d       = pc_i;
         mtval_d     = irq_take ? 32'd0 : exc_tval;
         set_mtval_d = ~irq_take;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         state_q     <= ST_RESET;
         cause_q     <= 5'd0;
         irq_q       <= 1'b0;
         epc_q       <= 32'd0;
         mtval_q     <= 32'd0;
         set_mtval_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cause_q     <= cause_d;
         irq_q       <= irq_d;
         epc_q       <= epc_d;
         mtval_q     <= mtval_d;
         set_mtval_q <= set_mtval_d;
      end
   end

   always_comb begin
      stall_o   = '0;
      stall_acc = 1'b0;
      if (n_rst_i) begin
         for (int j = MEM_STAGE; j >= 0; j--) begin
            stall_acc  = stall_acc | stallreq_i[j];
            stall_o[j] = stall_acc;
         end
`ifdef CTRL_WFI_EN
         if (state_q == ST_SLEEP) stall_o = {1'b0, {(NUM_STAGES-1){1'b1}}};
`endif
      end
   end

   assign trap_base = {mtvec_i[31:2], 2'b00};
   assign mcause_o  = {irq_q, 26'd0, cause_q};
   assign epc_o     = epc_q;
   assign mtval_o   = mtval_q;

   // Strobes are gated by the raw reset so they drop asynchronously on assertion.
   always_comb begin
      flush_o     = 1'b0;
      new_pc_o    = 32'd0;
      set_cause_o = 1'b0;
      set_epc_o   = 1'b0;
      set_mtval_o = 1'b0;
      mie_clear_o = 1'b0;
      mie_set_o   = 1'b0;
      if (n_rst_i) begin
         case (state_q)
            ST_RESET: begin
               flush_o  = 1'b1;
               new_pc_o = RESET_ADDR;
            end
            ST_TRAP_TAKEN: begin
               flush_o     = 1'b1;
               set_cause_o = 1'b1;
               set_epc_o   = 1'b1;
               mie_clear_o = 1'b1;
               set_mtval_o = set_mtval_q;
               new_pc_o    = (irq_q && mtvec_i[1:0] == 2'b01)
                           ? trap_base + {25'd0, cause_q, 2'b00}
                           : trap_base;
            end
            ST_TRAP_RETURN: begin
               flush_o   = 1'b1;
               mie_set_o = 1'b1;
               new_pc_o  = mepc_i;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_trap_ctrl_gen.sv
// Self-checking bench for trap_ctrl_gen: directed scenarios plus randomized trap traffic
// checked against a priority-list reference model.
module tb_trap_ctrl_gen;

   localparam int          NS     = 6;
   localparam int          NL     = 4;
   localparam logic [31:0] RST_PC = 32'h0000_0200;

   localparam int E_MRET = 0, E_ECALL = 1, E_EBRK = 2, E_MISI = 3, E_ILL = 4, E_STORE = 5, E_LOAD = 6;

   logic          clk_i = 1'b0;
   logic          n_rst_i;
   logic [NS-1:0] stallreq_i;
   logic [6:0]    exception_i;
   logic [31:0]   pc_i, inst_i, mie_i, mip_i, mtvec_i, mepc_i;
   logic          mstatus_mie_i;
   logic [NS-1:0] stall_o;
   logic          flush_o, set_cause_o, set_epc_o, set_mtval_o, mie_clear_o, mie_set_o;
   logic [31:0]   new_pc_o, mcause_o, epc_o, mtval_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   trap_ctrl_gen #(.NUM_STAGES(NS), .NUM_LIC(NL), .RESET_ADDR(RST_PC)) dut (
      .clk_i(clk_i), .n_rst_i(n_rst_i), .stallreq_i(stallreq_i), .exception_i(exception_i),
      .pc_i(pc_i), .inst_i(inst_i), .mstatus_mie_i(mstatus_mie_i), .mie_i(mie_i), .mip_i(mip_i),
      .mtvec_i(mtvec_i), .mepc_i(mepc_i), .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
      .set_cause_o(set_cause_o), .mcause_o(mcause_o), .set_epc_o(set_epc_o), .epc_o(epc_o),
      .set_mtval_o(set_mtval_o), .mtval_o(mtval_o), .mie_clear_o(mie_clear_o), .mie_set_o(mie_set_o)
   );

   // ---------------- reference model ----------------
   function automatic logic [NS-1:0] ref_stall(input logic [NS-1:0] req);
      logic [NS-1:0] r;
      r = '0;
      for (int j = 0; j < NS - 1; j++)
         for (int k = j; k < NS - 1; k++)
            if (req[k]) r[j] = 1'b1;
      return r;
   endfunction

   task automatic ref_trap(input logic [6:0] exc, input logic [31:0] en, input logic [31:0] pend,
                           input logic gie, input logic [31:0] pc, input logic [31:0] inst,
                           output logic took, output logic [31:0] cause, output logic [31:0] tval,
                           output logic tval_we);
      logic [31:0] ip;
      int          code;
      ip = en & pend;
      code = -1;
      took = 1'b0; cause = 32'd0; tval = 32'd0; tval_we = 1'b0;
      if (gie) begin
         for (int i = 0; i < NL; i++) if (ip[16+i]) code = 16 + i;
         if (code < 0) begin
            if (ip[11])     code = 11;
            else if (ip[3]) code = 3;
            else if (ip[7]) code = 7;
         end
         if (code >= 0) begin
            took = 1'b1; cause = 32'h8000_0000 | 32'(code);
            return;
         end
      end
      if (exc[E_MISI])       begin code = 0;  tval = pc;   end
      else if (exc[E_ILL])   begin code = 2;  tval = inst; end
      else if (exc[E_EBRK])  begin code = 3;  tval = pc;   end
      else if (exc[E_STORE]) begin code = 6;  tval = pc;   end
      else if (exc[E_LOAD])  begin code = 4;  tval = pc;   end
      else if (exc[E_ECALL]) begin code = 11; tval = 0;    end
      if (code >= 0) begin
         took = 1'b1; cause = 32'(code); tval_we = 1'b1;
      end
   endtask

   function automatic logic [31:0] ref_target(input logic [31:0] tvec, input logic [31:0] cause);
      logic [31:0] base;
      base = tvec & 32'hFFFF_FFFC;
      if (tvec[1:0] == 2'b01 && cause[31]) return base + 32'(cause[4:0]) * 4;
      return base;
   endfunction

   // ---------------- helpers ----------------
   task automatic idle_inputs();
      stallreq_i = '0; exception_i = '0; pc_i = '0; inst_i = '0;
      mie_i = '0; mip_i = '0; mstatus_mie_i = 1'b0;
   endtask

   task automatic step();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      n_rst_i = 1'b0;
      idle_inputs();
      stallreq_i = 6'b010000; exception_i = 7'b0000010; mstatus_mie_i = 1'b1;
      mie_i = 32'h80; mip_i = 32'h80;
      @(negedge clk_i);
      checks++;
      if ({stall_o, flush_o, set_cause_o, set_epc_o, set_mtval_o, mie_clear_o, mie_set_o} !== 12'd0) begin
         errors++; $display("FAIL reset_strobes: got %b, expected 0",
            {stall_o, flush_o, set_cause_o, set_epc_o, set_mtval_o, mie_clear_o, mie_set_o});
      end
      checks++;
      if ({mcause_o, epc_o, mtval_o, new_pc_o} !== 128'd0) begin
         errors++; $display("FAIL reset_values: got %h %h %h %h, expected all 0", mcause_o, epc_o, mtval_o, new_pc_o);
      end
      idle_inputs();
      n_rst_i = 1'b1;
      #1;
      checks++;
      if ({flush_o, new_pc_o, set_cause_o} !== {1'b1, RST_PC, 1'b0}) begin
         errors++; $display("FAIL reset_fetch: got flush=%b pc=%h cause_we=%b, expected 1 %h 0",
            flush_o, new_pc_o, set_cause_o, RST_PC);
      end
      step();
      checks++;
      if ({flush_o, new_pc_o} !== 33'd0) begin
         errors++; $display("FAIL reset_operating: got flush=%b pc=%h, expected 0 0", flush_o, new_pc_o);
      end
   endtask

   task automatic test_stall();
      logic [NS-1:0] pats [3] = '{6'b000100, 6'b010010, 6'b100000};
      logic [NS-1:0] exps [3] = '{6'b000111, 6'b011111, 6'b000000};
      logic [NS-1:0] r;
      for (int i = 0; i < 3; i++) begin
         stallreq_i = pats[i];
         #1;
         checks++;
         if (stall_o !== exps[i]) begin
            errors++; $display("FAIL stall_dir[%0d]: got %b, expected %b", i, stall_o, exps[i]);
         end
      end
      for (int i = 0; i < 20; i++) begin
         r = NS'($urandom);
         stallreq_i = r;
         #1;
         checks++;
         if (stall_o !== ref_stall(r)) begin
            errors++; $display("FAIL stall_rnd[%0d]: req %b got %b, expected %b", i, r, stall_o, ref_stall(r));
         end
      end
      stallreq_i = '0;
      @(negedge clk_i);
   endtask

   task automatic test_mti_vectored();
      mtvec_i = 32'h0000_1001; mstatus_mie_i = 1'b1; mie_i = 32'h80; mip_i = 32'h80; pc_i = 32'h44;
      step();
      checks++;
      if ({flush_o, mie_clear_o, set_cause_o, set_epc_o, set_mtval_o} !== 5'b11110) begin
         errors++; $display("FAIL mti_strobes: got %b, expected 11110",
            {flush_o, mie_clear_o, set_cause_o, set_epc_o, set_mtval_o});
      end
      checks++;
      if ({new_pc_o, mcause_o, epc_o} !== {32'h0000_101C, 32'h8000_0007, 32'h44}) begin
         errors++; $display("FAIL mti_values: got pc=%h cause=%h epc=%h, expected 101c 80000007 44",
            new_pc_o, mcause_o, epc_o);
      end
      idle_inputs();
      step();
      checks++;
      if (flush_o !== 1'b0) begin
         errors++; $display("FAIL mti_return_op: got flush=%b, expected 0", flush_o);
      end
   endtask

   task automatic test_illegal();
      exception_i[E_ILL] = 1'b1; inst_i = 32'hDEAD_BEEF; pc_i = 32'h100;
      step();
      checks++;
      if ({mcause_o, mtval_o, epc_o, new_pc_o} !== {32'd2, 32'hDEAD_BEEF, 32'h100, 32'h0000_1000}) begin
         errors++; $display("FAIL illegal_values: got cause=%h tval=%h epc=%h pc=%h, expected 2 deadbeef 100 1000",
            mcause_o, mtval_o, epc_o, new_pc_o);
      end
      checks++;
      if ({flush_o, set_mtval_o} !== 2'b11) begin
         errors++; $display("FAIL illegal_strobes: got flush=%b tval_we=%b, expected 1 1", flush_o, set_mtval_o);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_drain();
      exception_i[E_ECALL] = 1'b1; pc_i = 32'h300; stallreq_i = 6'b010000;
      for (int k = 0; k < 3; k++) begin
         step();
         // A higher-priority interrupt during the drain must not replace the latched cause.
         exception_i = '0; mstatus_mie_i = 1'b1; mie_i = 32'h0008_0000; mip_i = 32'h0008_0000; pc_i = 32'h999;
         checks++;
         if ({flush_o, set_cause_o, mcause_o} !== {2'b00, 32'd11}) begin
            errors++; $display("FAIL drain_hold[%0d]: got flush=%b cause_we=%b cause=%h, expected 0 0 b",
               k, flush_o, set_cause_o, mcause_o);
         end
      end
      stallreq_i = '0;
      step();
      checks++;
      if ({flush_o, set_cause_o, set_mtval_o, mcause_o, epc_o, mtval_o, new_pc_o}
          !== {3'b111, 32'd11, 32'h300, 32'd0, 32'h1000}) begin
         errors++; $display("FAIL drain_take: got flush=%b we=%b tval_we=%b cause=%h epc=%h tval=%h pc=%h",
            flush_o, set_cause_o, set_mtval_o, mcause_o, epc_o, mtval_o, new_pc_o);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_mret();
      mepc_i = 32'h0000_2040; exception_i[E_MRET] = 1'b1;
      step();
      checks++;
      if ({flush_o, mie_set_o, mie_clear_o, set_cause_o, new_pc_o} !== {4'b1100, 32'h2040}) begin
         errors++; $display("FAIL mret: got flush=%b set=%b clr=%b we=%b pc=%h, expected 1 1 0 0 2040",
            flush_o, mie_set_o, mie_clear_o, set_cause_o, new_pc_o);
      end
      idle_inputs();
      step();
      exception_i[E_MRET] = 1'b1; exception_i[E_ECALL] = 1'b1; pc_i = 32'h500;
      step();
      checks++;
      if ({flush_o, mie_set_o, set_cause_o, mcause_o, new_pc_o} !== {3'b101, 32'd11, 32'h1000}) begin
         errors++; $display("FAIL mret_ecall: got flush=%b set=%b we=%b cause=%h pc=%h, expected 1 0 1 b 1000",
            flush_o, mie_set_o, set_cause_o, mcause_o, new_pc_o);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_local_irq();
      mie_i = 32'h000A_0800; mip_i = 32'h000A_0800; mstatus_mie_i = 1'b0;
      step();
      checks++;
      if (flush_o !== 1'b0) begin
         errors++; $display("FAIL lic_masked: got flush=%b, expected 0", flush_o);
      end
      mstatus_mie_i = 1'b1;
      step();
      checks++;
      if ({flush_o, mcause_o, new_pc_o} !== {1'b1, 32'h8000_0013, 32'h0000_104C}) begin
         errors++; $display("FAIL lic_prio: got flush=%b cause=%h pc=%h, expected 1 80000013 104c",
            flush_o, mcause_o, new_pc_o);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_reset_mid_trap();
      exception_i[E_ILL] = 1'b1; inst_i = 32'h1234_5678; pc_i = 32'h600;
      step();
      n_rst_i = 1'b0;
      #1;
      checks++;
      if ({flush_o, set_cause_o, set_epc_o, set_mtval_o, mie_clear_o, mcause_o, epc_o, mtval_o, new_pc_o} !== '0) begin
         errors++; $display("FAIL rst_mid_trap: got flush=%b we=%b cause=%h epc=%h tval=%h pc=%h, expected all 0",
            flush_o, set_cause_o, mcause_o, epc_o, mtval_o, new_pc_o);
      end
      idle_inputs();
      @(negedge clk_i);
      n_rst_i = 1'b1;
      // Second abandonment: reset while draining.
      step();
      exception_i[E_ECALL] = 1'b1; stallreq_i = 6'b010000;
      step();
      n_rst_i = 1'b0;
      #1;
      idle_inputs();
      @(negedge clk_i);
      n_rst_i = 1'b1;
      #1;
      checks++;
      if ({flush_o, new_pc_o, set_cause_o, set_epc_o} !== {1'b1, RST_PC, 2'b00}) begin
         errors++; $display("FAIL rst_mid_drain: got flush=%b pc=%h we=%b, expected 1 %h 0",
            flush_o, new_pc_o, set_cause_o, RST_PC);
      end
      step();
      checks++;
      if ({flush_o, set_cause_o} !== 2'b00) begin
         errors++; $display("FAIL rst_abandon: got flush=%b we=%b, expected 0 0", flush_o, set_cause_o);
      end
   endtask

   task automatic test_random();
      logic        took, tval_we;
      logic [31:0] cause, tval, exp_pc, pc_s, mepc_s;
      logic [6:0]  exc;
      int          drain;
      for (int it = 0; it < 150; it++) begin
         for (int b = 0; b < 7; b++) exc[b] = ($urandom_range(0, 7) == 0);
         exception_i   = exc;
         mie_i         = $urandom & $urandom;
         mip_i         = $urandom & $urandom;
         mstatus_mie_i = 1'($urandom_range(0, 1));
         pc_i          = $urandom; inst_i = $urandom; mtvec_i = $urandom; mepc_i = $urandom;
         drain         = $urandom_range(0, 3);
         stallreq_i    = NS'($urandom) & 6'b101111;
         if (drain > 0) stallreq_i[NS-2] = 1'b1;
         pc_s = pc_i; mepc_s = mepc_i;
         ref_trap(exc, mie_i, mip_i, mstatus_mie_i, pc_i, inst_i, took, cause, tval, tval_we);
         exp_pc = ref_target(mtvec_i, cause);
         #1;
         checks++;
         if (stall_o !== ref_stall(stallreq_i)) begin
            errors++; $display("FAIL rnd_stall[%0d]: got %b, expected %b", it, stall_o, ref_stall(stallreq_i));
         end
         step();
         if (took && drain > 0) begin
            for (int k = 0; k < drain; k++) begin
               checks++;
               if (flush_o !== 1'b0) begin
                  errors++; $display("FAIL rnd_drain[%0d.%0d]: got flush=%b, expected 0", it, k, flush_o);
               end
               exception_i = 7'($urandom); mie_i = $urandom; mip_i = $urandom; pc_i = $urandom;
               if (k == drain - 1) stallreq_i = '0;
               step();
            end
         end
         if (took) begin
            checks++;
            if ({flush_o, set_cause_o, set_epc_o, mie_clear_o, mie_set_o, set_mtval_o} !== {5'b11110, tval_we}) begin
               errors++; $display("FAIL rnd_trap_strobes[%0d]: got %b, expected %b", it,
                  {flush_o, set_cause_o, set_epc_o, mie_clear_o, mie_set_o, set_mtval_o}, {5'b11110, tval_we});
            end
            checks++;
            if ({mcause_o, epc_o, mtval_o, new_pc_o} !== {cause, pc_s, tval, exp_pc}) begin
               errors++; $display("FAIL rnd_trap_values[%0d]: got %h %h %h %h, expected %h %h %h %h", it,
                  mcause_o, epc_o, mtval_o, new_pc_o, cause, pc_s, tval, exp_pc);
            end
         end else if (exc[E_MRET]) begin
            checks++;
            if ({flush_o, mie_set_o, set_cause_o, new_pc_o} !== {3'b110, mepc_s}) begin
               errors++; $display("FAIL rnd_mret[%0d]: got flush=%b set=%b we=%b pc=%h, expected 1 1 0 %h", it,
                  flush_o, mie_set_o, set_cause_o, new_pc_o, mepc_s);
            end
         end else begin
            checks++;
            if ({flush_o, set_cause_o, mie_set_o} !== 3'b000) begin
               errors++; $display("FAIL rnd_idle[%0d]: got flush=%b we=%b set=%b, expected 0 0 0", it,
                  flush_o, set_cause_o, mie_set_o);
            end
         end
         idle_inputs();
         if (took || exc[E_MRET]) step();
      end
   endtask

   initial begin
      n_rst_i = 1'b0;
      idle_inputs();
      mtvec_i = 32'h0000_1001;
      mepc_i  = 32'd0;
      test_reset();
      test_stall();
      test_mti_vectored();
      test_illegal();
      test_drain();
      test_mret();
      test_local_irq();
      test_reset_mid_trap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
